adder_arbiter: RTL and testbench
================================

// Module: adder_arbiter
//
// PURPOSE
// - Round-robin arbiter sharing one 32-bit combinational adder among NUM_REQ requesters.
// - Requesters present operand pairs with a valid/ready handshake.
// - The winner's operands are added and the result is registered into a one-deep
//   response slot, tagged with the requester index.
// - Sits between PC/branch-target/address-gen clients and a single shared adder to save area.
//
// PARAMETERS
// - NUM_REQ  4                   number of requesters; legal range 2..16
// - ID_W     $clog2(NUM_REQ)     requester index width; derived, not overridden
//
// PORTS
// - clk        in   1             single clock, rising edge
// - rst_n      in   1             asynchronous, active-low reset
// - req_valid  in   NUM_REQ       per-requester operand-valid
// - req_a      in   NUM_REQ x 32  operand A per requester (packed [NUM_REQ-1:0][31:0])
// - req_b      in   NUM_REQ x 32  operand B per requester
// - req_ready  out  NUM_REQ       one-hot-or-zero grant/accept
// - rsp_valid  out  1             result slot holds a valid sum
// - rsp_ready  in   1             downstream consumes result this cycle
// - rsp_sum    out  32            registered sum of the granted operands
// - rsp_id     out  ID_W          index of the requester that produced rsp_sum
//
// BEHAVIOUR
// - Reset (rst_n=0, async): rsp_valid=0, rsp_sum=0, rsp_id=0, rr_ptr=0, state=IDLE.
//   req_ready=0 while in reset.
// - Sum rules: rsp_sum = (a + b) mod 2^32, unsigned; carry-out is discarded.
// - Slot state machine:
//   - IDLE: slot empty.
//   - FULL: slot holds an unconsumed result.
// - slot_free = (state==IDLE) | (rsp_valid & rsp_ready).
// - Arbitration, combinational each cycle:
//   - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
//   - The first set bit is the winner.
//   - req_ready[winner] = slot_free; all other req_ready bits are 0.
//   - req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
// - Accept = |(req_valid & req_ready). On accept, at the next rising edge:
//   - rsp_sum <= a+b of the winner, rsp_id <= winner, rsp_valid <= 1, state <= FULL.
//   - rr_ptr <= (winner+1) mod NUM_REQ.
// - Latency: one cycle from accept to rsp_valid.
// - Throughput: one result per cycle while rsp_ready=1 (drain and refill in the same cycle).
// - FULL & rsp_ready & no accept -> IDLE, rsp_valid <= 0. rsp_sum and rsp_id hold their last value.
// - FULL & ~rsp_ready -> hold rsp_sum/rsp_id/rsp_valid stable; req_ready all 0 (backpressure).
// - No accept leaves rr_ptr unchanged. Fairness: a continuously valid requester waits at most
//   NUM_REQ-1 accepts.
// - Requester obligations: once req_valid rises, it holds, and operands stay stable, until accepted.
// - Reset mid-operation: any held result is dropped. Requesters must re-present their operands.
// - Width guard: NUM_REQ that is not a power of two wraps explicitly at NUM_REQ-1 -> 0,
//   never through ID_W overflow.
//
// STRUCTURE
// - Shared package adder_arb_pkg:
//   - typedef enum logic {IDLE, FULL} arb_state_e;
//   - localparam DATA_W = 32.
// - Sub-module: instantiate the team's combinational `adder` (a, b -> sum) once.
//   Feed it from the winner's operand mux.
// - Sub-module: rr_picker (NUM_REQ). Maps req_valid and rr_ptr to winner and any_valid.
//   Purely combinational, reusable by other arbiters.
// - Sequential logic (state, slot, rr_ptr) lives in adder_arbiter using always_ff with
//   negedge rst_n.
//
// TESTING
// - Reset: assert rst_n=0 mid-FULL -> rsp_valid=0, rsp_sum=0, rsp_id=0 immediately.
//   Then the first grant goes to requester 0.
// - Single request: req 2 presents a=0x0000_0010, b=0x0000_0004 with rsp_ready=1.
//   -> req_ready=4'b0100 the same cycle; next cycle rsp_valid=1, rsp_sum=0x14, rsp_id=2.
// - Wrap-around: a=0xFFFF_FFFF, b=0x0000_0002 -> rsp_sum=0x0000_0001; no carry output.
// - Round robin: all 4 valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,...
//   One result per cycle.
// - Backpressure: slot FULL with rsp_ready=0 for 3 cycles -> req_ready=0.
//   rsp_sum and rsp_id are stable; on release, drain and refill in the same cycle.
// - Simultaneous events: rr_ptr=3, only reqs 1 and 3 valid -> 3 wins, then 1.
//   Req 0 rising late does not preempt req 1.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the shared-adder arbiter slice.
package adder_arb_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } arb_state_e;

endpackage

// File: rtl/adder.sv
// Combinational unsigned adder; carry-out is intentionally discarded.
module adder
    import adder_arb_pkg::*;
#(
    parameter int unsigned W = DATA_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/rr_picker.sv
// Round-robin picker: first set req_valid bit at or after rr_ptr, wrapping at NUM_REQ-1.
module rr_picker #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    winner,
    output logic               any_valid
);

    always_comb begin
        int unsigned idx;
        logic [ID_W-1:0] idx_w;
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        idx_w     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            // Explicit modulo so non-power-of-two counts never rely on ID_W overflow
            idx = 32'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = idx[ID_W-1:0];
            if (!any_valid && req_valid[idx_w]) begin
                winner    = idx_w;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 32-bit adder among NUM_REQ requesters,
// with a one-deep registered response slot tagged by requester index.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_a,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_b,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [DATA_W-1:0]               rsp_sum,
    output logic [ID_W-1:0]                 rsp_id
);

    arb_state_e        state_q, state_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;

    logic [ID_W-1:0]   winner;
    logic              any_valid;
    logic              slot_free;
    logic              accept;
    logic [DATA_W-1:0] add_sum;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_valid (req_valid),
        .rr_ptr    (ptr_q),
        .winner    (winner),
        .any_valid (any_valid)
    );

    adder #(
        .W (DATA_W)
    ) u_adder (
        .a   (req_a[winner]),
        .b   (req_b[winner]),
        .sum (add_sum)
    );

    assign rsp_valid = (state_q == FULL);
    assign slot_free = (state_q == IDLE) || (rsp_valid && rsp_ready);
    // rst_n gates the grant so nothing is offered while reset is held
    assign accept    = any_valid && slot_free && rst_n;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        if (accept) begin
            state_d = FULL;
            sum_d   = add_sum;
            id_d    = winner;
            ptr_d   = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end else if ((state_q == FULL) && rsp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sum_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign rsp_sum = sum_q;
    assign rsp_id  = id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized and directed bench for adder_arbiter against a queue-free behavioural model.
module tb_adder_arbiter;

    localparam int N = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N-1:0]         req_valid;
    logic [N-1:0][31:0]   req_a;
    logic [N-1:0][31:0]   req_b;
    logic [N-1:0]         req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_sum;
    logic [1:0]           rsp_id;

    always #5 clk = ~clk;

    adder_arbiter #(
        .NUM_REQ (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: pending requesters, their operands, the result slot and the search start
    bit          pend [N];
    logic [31:0] opa  [N];
    logic [31:0] opb  [N];
    bit          m_valid;
    logic [31:0] m_sum;
    int          m_id;
    int          m_ptr;
    bit          rdy;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = pend[i];
            req_a[i]     = opa[i];
            req_b[i]     = opb[i];
        end
        rsp_ready = rdy;
    endtask

    task automatic present(input int i, input logic [31:0] a, input logic [31:0] b);
        if (!pend[i]) begin
            pend[i] = 1'b1;
            opa[i]  = a;
            opb[i]  = b;
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_sum   = '0;
        m_id    = 0;
        m_ptr   = 0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            opa[i]  = '0;
            opb[i]  = '0;
        end
    endtask

    // One clock of traffic: check the grant, advance the model, check the slot.
    task automatic cycle();
        int w;
        logic [N-1:0] exp_rdy;
        w = -1;
        drive();
        #1;
        for (int k = 0; k < N; k++) begin
            if (w < 0 && pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        end
        exp_rdy = '0;
        if (w >= 0 && (!m_valid || rdy)) exp_rdy[w] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        @(posedge clk);
        if (exp_rdy != '0) begin
            m_sum   = opa[w] + opb[w];
            m_id    = w;
            m_valid = 1'b1;
            m_ptr   = (w + 1) % N;
            pend[w] = 1'b0;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        #1;
        check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
        check("rsp_sum", 64'(rsp_sum), 64'(m_sum));
        check("rsp_id", 64'(rsp_id), 64'(m_id));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_sum", 64'(rsp_sum), 64'd0);
        check("rst_id", 64'(rsp_id), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        model_reset();
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hold_sum;
        logic [1:0]  hold_id;
        model_reset();
        rdy = 1'b1;
        for (int i = 0; i < N; i++) pend[i] = 1'b1;
        drive();
        #12;
        apply_reset();

        // Single request from requester 2
        present(2, 32'h0000_0010, 32'h0000_0004);
        cycle();
        check("single_sum", 64'(rsp_sum), 64'h14);
        check("single_id", 64'(rsp_id), 64'd2);

        // Wrap-around sum; pointer now at 3, only requester 0 waiting
        present(0, 32'hFFFF_FFFF, 32'h0000_0002);
        cycle();
        check("wrap_sum", 64'(rsp_sum), 64'h1);
        check("wrap_id", 64'(rsp_id), 64'd0);

        // Fill the slot, then reset while it is held
        present(1, 32'd7, 32'd8);
        rdy = 1'b0;
        cycle();
        check("full_before_rst", 64'(rsp_valid), 64'd1);
        #2;
        apply_reset();

        // Round robin with everyone continuously valid
        rdy = 1'b1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) present(i, $urandom, $urandom);
            cycle();
            check("rr_id", 64'(rsp_id), 64'(c % N));
        end

        // Backpressure for three cycles, then drain and refill together
        hold_sum = rsp_sum;
        hold_id  = rsp_id;
        rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N; i++) present(i, $urandom, $urandom);
            cycle();
            check("bp_ready", 64'(req_ready), 64'd0);
            check("bp_sum", 64'(rsp_sum), 64'(hold_sum));
            check("bp_id", 64'(rsp_id), 64'(hold_id));
        end
        rdy = 1'b1;
        cycle();
        check("refill_valid", 64'(rsp_valid), 64'd1);
        check("refill_id", 64'(rsp_id), 64'((hold_id + 1) % N));

        // Pointer at 3 with only 1 and 3 valid; 0 arrives after 1 wins
        apply_reset();
        rdy = 1'b1;
        present(2, 32'd1, 32'd1);
        cycle();
        present(1, 32'd100, 32'd1);
        present(3, 32'd300, 32'd3);
        cycle();
        check("simul_first", 64'(rsp_id), 64'd3);
        cycle();
        check("simul_second", 64'(rsp_id), 64'd1);
        present(0, 32'd5, 32'd6);
        cycle();
        check("simul_late0", 64'(rsp_id), 64'd0);
        check("simul_late0_sum", 64'(rsp_sum), 64'd11);

        // Random traffic and random backpressure
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) present(i, $urandom, $urandom);
            end
            rdy = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
